// File: rtl/branch_sequencer.sv
// Branch sequencer: flag register, branch condition evaluation, PC update and flush pulse; taken counter with BRANCH_STATS_EN.
// Latency: branch decision visible on pc/taken/flush one clk edge after the input cycle.
// Backpressure: stall freezes pc, flags and flush counter, and suppresses taken.
module branch_sequencer #(
    parameter int                ADDR_W       = 16,
    parameter int                OPCODE_W     = 4,
    parameter int                OFFSET_W     = 8,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int                FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                br_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [ADDR_W-1:0]   abs_target,
    input  logic                use_abs,
    input  logic                flag_we,
    input  logic                neg_in,
    input  logic                zero_in,
    input  logic                carry_in,
    input  logic                ovf_in,
    output logic [ADDR_W-1:0]   pc,
    output logic                taken,
    output logic                flush,
    output logic [3:0]          flags,
    output logic [15:0]         taken_count
);

    localparam logic [3:0] OP_JMP = 4'b0001;
    localparam logic [3:0] OP_BGT = 4'b0100;
    localparam logic [3:0] OP_BLT = 4'b0101;
    localparam logic [3:0] OP_BEQ = 4'b0110;
    localparam logic [3:0] OP_BNE = 4'b0111;
    localparam logic [3:0] OP_BGE = 4'b1000;
    localparam logic [3:0] OP_BLE = 4'b1001;
    localparam logic [3:0] OP_BCS = 4'b1010;
    localparam logic [3:0] OP_BVS = 4'b1011;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    logic [3:0]        flag_q;
    logic [3:0]        eff_flags;
    logic              eff_n;
    logic              eff_z;
    logic              eff_c;
    logic              eff_v;
    logic              op_upper_zero;
    logic              cond_hit;
    logic              cond_taken;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] offset_ext;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_next;
    logic [3:0]        flush_cnt;
    logic [3:0]        flush_cnt_next;
    logic              flush_q;
    logic              taken_q;

    // Wider opcodes are only branches when the bits above [3:0] are clear.
    generate
        if (OPCODE_W > 4) begin : g_wide_op
            assign op_upper_zero = ~|opcode[OPCODE_W-1:4];
        end else begin : g_narrow_op
            assign op_upper_zero = 1'b1;
        end
    endgenerate

    // Same-cycle forwarding lets a flag-setting op feed the branch right behind it.
    assign eff_flags = flag_we ? {neg_in, zero_in, carry_in, ovf_in} : flag_q;
    assign eff_n     = eff_flags[3];
    assign eff_z     = eff_flags[2];
    assign eff_c     = eff_flags[1];
    assign eff_v     = eff_flags[0];

    always_comb begin
        cond_hit = 1'b0;
        case (opcode[3:0])
            OP_JMP:  cond_hit = 1'b1;
            OP_BGT:  cond_hit = ~eff_n & ~eff_z;
            OP_BLT:  cond_hit = eff_n;
            OP_BEQ:  cond_hit = eff_z;
            OP_BNE:  cond_hit = ~eff_z;
            OP_BGE:  cond_hit = ~eff_n;
            OP_BLE:  cond_hit = eff_n | eff_z;
            OP_BCS:  cond_hit = eff_c;
            OP_BVS:  cond_hit = eff_v;
            default: cond_hit = 1'b0;
        endcase
    end

    assign cond_taken = br_valid & ~stall & op_upper_zero & cond_hit;

    assign offset_ext = ADDR_W'($signed(offset));
    assign target     = use_abs ? abs_target : pc_q + offset_ext;
    assign pc_next    = cond_taken ? target : pc_q + ADDR_W'(1);

    // A taken branch restarts the flush window rather than extending it.
    always_comb begin
        flush_cnt_next = flush_cnt;
        if (!stall) begin
            if (cond_taken) begin
                flush_cnt_next = FLUSH_LOAD;
            end else if (flush_cnt != 4'd0) begin
                flush_cnt_next = flush_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            flag_q    <= 4'd0;
            taken_q   <= 1'b0;
            flush_cnt <= 4'd0;
            flush_q   <= 1'b0;
        end else if (stall) begin
            taken_q   <= 1'b0;
        end else begin
            pc_q      <= pc_next;
            taken_q   <= cond_taken;
            flush_cnt <= flush_cnt_next;
            flush_q   <= (flush_cnt_next != 4'd0);
            if (flag_we) begin
                flag_q <= {neg_in, zero_in, carry_in, ovf_in};
            end
        end
    end

    assign pc    = pc_q;
    assign taken = taken_q;
    assign flush = flush_q;
    assign flags = flag_q;

`ifdef BRANCH_STATS_EN
    logic [15:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 16'd0;
        end else if (cond_taken && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign taken_count = count_q;
`else
    assign taken_count = 16'd0;
`endif

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
Parametrised successor to the combinational jump-condition decoder. Holds the condition-flag register (N/Z/C/V) and evaluates an extended branch-condition set, with same-cycle flag forwarding. Owns the program-counter register and computes PC-relative or absolute targets. Generates a multi-cycle pipeline flush after every taken branch. Sits between the ALU flag outputs and instruction fetch.

Parameters:
ADDR_W, 16, PC and target width
OPCODE_W, 4, opcode width, minimum 4; opcode bits above [3:0] must be zero for any branch
OFFSET_W, 8, signed PC-relative offset width, must be <= ADDR_W
RESET_PC, 0, PC value after reset
FLUSH_CYCLES, 2, flush pulse length in cycles, range 1..15

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
stall  in  1  freeze PC, flags, and flush counter
br_valid  in  1  opcode/offset/target valid this cycle
opcode  in  OPCODE_W  branch opcode
offset  in  OFFSET_W  signed two's-complement relative offset
abs_target  in  ADDR_W  absolute target address
use_abs  in  1  1 = abs_target, 0 = pc + offset
flag_we  in  1  load flag register
neg_in, zero_in, carry_in, ovf_in  in  1 each  ALU flags
pc  out  ADDR_W  current program counter
taken  out  1  registered, 1-cycle pulse: branch taken
flush  out  1  registered flush request
flags  out  4  {N,Z,C,V} register contents
taken_count  out  16  taken-branch counter (see Optional Feature)

Behaviour:
- Reset: synchronous, clk edge with rst_n=0. pc=RESET_PC, flags=0, taken=0, flush=0, flush counter=0, taken_count=0. Reset overrides stall and any in-flight flush.
- Effective flags: if flag_we=1, use the input flags in the same cycle (forwarding). Otherwise use the flags register.
- Conditions (opcode[3:0], upper bits zero):
  - 0001 JMP: always
  - 0100 BGT: !N & !Z
  - 0101 BLT: N
  - 0110 BEQ: Z
  - 0111 BNE: !Z
  - 1000 BGE: !N
  - 1001 BLE: N | Z
  - 1010 BCS: C
  - 1011 BVS: V
  - All other opcodes: never taken.
- cond_taken = br_valid & !stall & condition.
- Target: use_abs ? abs_target : pc + sign_extend(offset). Arithmetic is mod 2^ADDR_W and wraps in both directions.
- Each edge with stall=0:
  - pc <= cond_taken ? target : pc+1 (wraps from all-ones to 0).
  - taken <= cond_taken.
  - Flags register loads the input flags if flag_we=1.
- Each edge with stall=1:
  - pc, flags, and flush counter hold.
  - taken <= 0.
  - flag_we and br_valid are ignored.
- Flush counter:
  - Loads FLUSH_CYCLES on the edge where cond_taken=1.
  - Otherwise decrements when nonzero and not stalled.
  - flush = (counter != 0), registered.
  - A taken branch during an active flush reloads the counter to FLUSH_CYCLES; no accumulation.
- Latency: the branch decision is visible on pc, taken, and flush one edge after the input cycle.

Optional Feature:
Macro BRANCH_STATS_EN.
- Defined: taken_count increments on every edge where cond_taken=1 and saturates at 16'hFFFF. Cleared by reset.
- Undefined: taken_count is tied to 0 and no counter logic is instantiated.

Test Plan:
1. Reset with RESET_PC=16'h0100, then 3 idle cycles -> pc = 0101, 0102, 0103; taken=0; flush=0.
2. pc=0x0010, br_valid=1, opcode=0001, use_abs=0, offset=8'hFC -> next pc=0x000C; taken=1 for 1 cycle; flush=1 for exactly 2 cycles.
3. Flags forwarding: flag_we=1, zero_in=1 in the same cycle as BEQ with use_abs=1, abs_target=0x0200 -> pc=0x0200. Next cycle BNE with flag_we=0 -> not taken, pc=0x0201.
4. Condition matrix: for each NZ ∈ {00, 01, 10} issue BGT/BLT/BGE/BLE. Required taken:
   - NZ=00: BGT=1, BLT=0, BGE=1, BLE=0
   - NZ=01: BGT=0, BLT=0, BGE=1, BLE=1
   - NZ=10: BGT=0, BLT=1, BGE=0, BLE=1
   - Opcode 4'b1111 -> never taken.
5. Stall and wrap:
   - Stall held 3 cycles with br_valid=1 JMP -> pc and flush frozen, taken=0.
   - pc=0xFFFF with no branch -> next pc=0x0000.
   - pc=0xFFFE, offset=+4 -> pc=0x0002.
6. Mid-flush events:
   - Second taken branch on flush cycle 1 -> flush extends to 2 further cycles.
   - rst_n=0 mid-flush -> flush=0, pc=RESET_PC next edge.
   - With BRANCH_STATS_EN, 5 taken branches -> taken_count=5.
